// File: rtl/tlp_stream_packetizer.sv
// Sequential TLP packetizer: builds 3DW/4DW headers and streams header+payload as DATA_W beats with SOP/EOP/keep.
// Optional TLP_PKT_STATS_EN adds saturating sent/dropped counters.
module tlp_stream_packetizer #(
    parameter int DATA_W         = 128,
    parameter int MAX_PAYLOAD_DW = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic [2:0]                    header_fmt_i,
    input  logic [4:0]                    header_type_i,
    input  logic [2:0]                    header_tc_i,
    input  logic [9:0]                    header_length_i,
    input  logic [15:0]                   header_requestID_i,
    input  logic [15:0]                   header_completID_i,
    input  logic [63:0]                   address_i,
    input  logic [MAX_PAYLOAD_DW*32-1:0]  data_i,
    output logic                          tlp_valid_o,
    input  logic                          tlp_ready_i,
    output logic [DATA_W-1:0]             tlp_data_o,
    output logic [DATA_W/32-1:0]          tlp_keep_o,
    output logic                          tlp_sop_o,
    output logic                          tlp_eop_o,
    output logic                          err_o
`ifdef TLP_PKT_STATS_EN
    ,
    output logic [15:0]                   tlp_count_o,
    output logic [15:0]                   drop_count_o
`endif
);
    localparam int LANES  = DATA_W / 32;
    localparam int BUF_DW = MAX_PAYLOAD_DW + 4;
    localparam int IW     = $clog2(BUF_DW + LANES + 1);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SEND = 1'b1} state_t;

    state_t              state_q;
    logic [31:0]         buf_q [BUF_DW];
    logic [IW-1:0]       idx_q;
    logic [IW-1:0]       total_q;
    logic                valid_q, sop_q, eop_q, err_q;
    logic [DATA_W-1:0]   data_q;
    logic [LANES-1:0]    keep_q;

    logic                is_mem3_s, is_mem4_s, is_cpl_s, bad_s;
    logic [2:0]          hdr_dw_s;
    logic [10:0]         pay_dw_s;
    logic [IW-1:0]       total_d;
    logic [31:0]         asm_s [BUF_DW];
    int                  src_idx_s, src_total_s;
    logic [DATA_W-1:0]   beat_data_s;
    logic [LANES-1:0]    beat_keep_s;
    logic                beat_last_s;

    // Request decode: packet kind, header size, payload size and rejection
    always_comb begin
        is_mem3_s = (header_fmt_i == 3'b000 || header_fmt_i == 3'b010) && (header_type_i == 5'b00000);
        is_mem4_s = (header_fmt_i == 3'b001 || header_fmt_i == 3'b011) && (header_type_i == 5'b00000);
        is_cpl_s  = (header_fmt_i == 3'b000 || header_fmt_i == 3'b010) && (header_type_i == 5'b01010);
        hdr_dw_s  = is_mem4_s ? 3'd4 : 3'd3;
        pay_dw_s  = header_fmt_i[1] ? ((header_length_i == 10'd0) ? 11'd1024 : {1'b0, header_length_i})
                                    : 11'd0;
        bad_s     = !(is_mem3_s || is_mem4_s || is_cpl_s) || (pay_dw_s > 11'(MAX_PAYLOAD_DW));
        total_d   = IW'(hdr_dw_s) + IW'(pay_dw_s);
    end

    // Assemble header followed by payload into a DW image of the whole TLP
    always_comb begin
        for (int p = 0; p < BUF_DW; p++) begin
            asm_s[p] = 32'd0;
        end
        asm_s[0] = {header_fmt_i, header_type_i, 1'b0, header_tc_i, 10'b0, header_length_i};
        asm_s[1] = {header_requestID_i, 16'h0000};
        if (is_mem4_s) begin
            asm_s[2] = address_i[63:32];
            asm_s[3] = {address_i[31:2], 2'b00};
            for (int k = 0; k < MAX_PAYLOAD_DW; k++) begin
                asm_s[4+k] = data_i[MAX_PAYLOAD_DW*32-1-32*k -: 32];
            end
        end else if (is_cpl_s) begin
            asm_s[2] = {header_completID_i, 16'h0000};
            for (int k = 0; k < MAX_PAYLOAD_DW; k++) begin
                asm_s[3+k] = data_i[MAX_PAYLOAD_DW*32-1-32*k -: 32];
            end
        end else begin
            asm_s[2] = {address_i[31:2], 2'b00};
            for (int k = 0; k < MAX_PAYLOAD_DW; k++) begin
                asm_s[3+k] = data_i[MAX_PAYLOAD_DW*32-1-32*k -: 32];
            end
        end
    end

    // Next beat contents: first beat comes straight from the assembled image, later ones from the buffer
    always_comb begin
        beat_data_s = '0;
        beat_keep_s = '0;
        if (state_q == ST_IDLE) begin
            src_idx_s   = 0;
            src_total_s = int'(total_d);
        end else begin
            src_idx_s   = int'(idx_q) + LANES;
            src_total_s = int'(total_q);
        end
        for (int l = 0; l < LANES; l++) begin
            if ((src_idx_s + l) < src_total_s && (src_idx_s + l) < BUF_DW) begin
                if (state_q == ST_IDLE) begin
                    beat_data_s[DATA_W-1-32*l -: 32] = asm_s[src_idx_s + l];
                end else begin
                    beat_data_s[DATA_W-1-32*l -: 32] = buf_q[src_idx_s + l];
                end
                beat_keep_s[LANES-1-l] = 1'b1;
            end else begin
                beat_keep_s[LANES-1-l] = 1'b0;
            end
        end
        beat_last_s = (src_idx_s + LANES) >= src_total_s;
    end

    // Control FSM with registered beat outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            total_q <= '0;
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
            for (int p = 0; p < BUF_DW; p++) begin
                buf_q[p] <= 32'd0;
            end
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        if (bad_s) begin
                            err_q <= 1'b1;
                        end else begin
                            buf_q   <= asm_s;
                            total_q <= total_d;
                            idx_q   <= '0;
                            state_q <= ST_SEND;
                            valid_q <= 1'b1;
                            sop_q   <= 1'b1;
                            eop_q   <= beat_last_s;
                            data_q  <= beat_data_s;
                            keep_q  <= beat_keep_s;
                        end
                    end
                end
                ST_SEND: begin
                    if (tlp_ready_i) begin
                        if (eop_q) begin
                            state_q <= ST_IDLE;
                            valid_q <= 1'b0;
                            sop_q   <= 1'b0;
                            eop_q   <= 1'b0;
                            data_q  <= '0;
                            keep_q  <= '0;
                        end else begin
                            idx_q  <= idx_q + IW'(LANES);
                            sop_q  <= 1'b0;
                            eop_q  <= beat_last_s;
                            data_q <= beat_data_s;
                            keep_q <= beat_keep_s;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o = (state_q == ST_IDLE);
    assign tlp_valid_o = valid_q;
    assign tlp_sop_o   = sop_q;
    assign tlp_eop_o   = eop_q;
    assign tlp_data_o  = data_q;
    assign tlp_keep_o  = keep_q;
    assign err_o       = err_q;

`ifdef TLP_PKT_STATS_EN
    logic [15:0] tlp_cnt_q, drop_cnt_q;

    // Saturating counters of completed and rejected TLPs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tlp_cnt_q  <= 16'd0;
            drop_cnt_q <= 16'd0;
        end else begin
            if (state_q == ST_SEND && tlp_ready_i && eop_q && tlp_cnt_q != 16'hFFFF) begin
                tlp_cnt_q <= tlp_cnt_q + 16'd1;
            end
            if (err_q && drop_cnt_q != 16'hFFFF) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

    assign tlp_count_o  = tlp_cnt_q;
    assign drop_count_o = drop_cnt_q;
`endif
endmodule
